// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state encoding and word width for the SPI transmit arbiter.
package spi_arb_pkg;
  localparam int SPI_WORD_W = 18;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RELEASE} spi_arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin chooser, scanning upward from the slot after the last winner.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         win_o,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     any_o
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] j;
  logic found;
  always_comb begin
    win_o = '0;
    idx_o = '0;
    found = 1'b0;
    j = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = IW'((int'(ptr_i) + k) % N_REQ);
      if (!found && req_i[j]) begin
        found = 1'b1;
        win_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
  assign any_o = |req_i;
endmodule

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: shares one SPI master transmitter between N_REQ requesters,
// one latched word per transaction, with a start timeout on the master's busy.
module spi_tx_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int DATA_W        = SPI_WORD_W,
  parameter int START_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic [N_REQ-1:0]        done_o,
  output logic                    timeout_err_o,
  output logic                    spi_send_o,
  output logic [DATA_W-1:0]       spi_data_o,
  input  logic                    spi_busy_i
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  spi_arb_state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, pick_idx;
  logic [TW-1:0] timer_q, timer_d;
  logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d, pick_win;
  logic tmo_q, tmo_d, send_q, send_d, pick_any;
  logic [DATA_W-1:0] data_q, data_d;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    grant_d = grant_q;
    data_d  = data_q;
    done_d  = '0;
    tmo_d   = 1'b0;
    send_d  = 1'b0;
    unique case (state_q)
      IDLE: if (pick_any && !spi_busy_i) begin
        grant_d = pick_win;
        data_d  = req_data_i[pick_idx*DATA_W +: DATA_W];
        send_d  = 1'b1;
        ptr_d   = pick_idx;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (spi_busy_i) state_d = WAIT_DONE;
        else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = RELEASE;
        end else timer_d = timer_q + 1'b1;
      // no timeout once busy is seen: a transfer may run arbitrarily long
      WAIT_DONE: if (!spi_busy_i) begin
        done_d[ptr_q] = 1'b1;
        state_d = RELEASE;
      end
      RELEASE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      timer_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      tmo_q   <= 1'b0;
      send_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      send_q  <= send_d;
      data_q  <= data_d;
    end
  end

  assign grant_o       = grant_q;
  assign done_o        = done_q;
  assign timeout_err_o = tmo_q;
  assign spi_send_o    = send_q;
  assign spi_data_o    = data_q;
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb_spi_tx_arbiter: directed scenarios against a cycle-count transaction model
// plus a busy-line model of the SPI master.
module tb_spi_tx_arbiter;
  localparam int N = 4;
  localparam int W = 18;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] grant_o, done_o;
  logic timeout_err_o, spi_send_o;
  logic [W-1:0] spi_data_o;
  logic spi_busy, force_busy = 1'b0, mb = 1'b0;
  assign spi_busy = force_busy | mb;

  spi_tx_arbiter #(.N_REQ(N), .DATA_W(W), .START_TIMEOUT(T)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req),
    .req_data_i    (req_data),
    .grant_o       (grant_o),
    .done_o        (done_o),
    .timeout_err_o (timeout_err_o),
    .spi_send_o    (spi_send_o),
    .spi_data_o    (spi_data_o),
    .spi_busy_i    (spi_busy)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // master model: busy rises the cycle after send and stays high for bl cycles (bl=0: never)
  int bl = 40;
  int cnt = 0;
  initial forever begin
    @(negedge clk);
    if (cnt > 0) cnt--;
    if (spi_send_o && bl > 0) cnt = bl;
    mb = (cnt != 0);
  end

  // transaction model: counts edges since the grant instead of tracking FSM states
  int m_owner, m_last, m_age;
  bit m_seen, m_rel;
  logic [N-1:0] e_grant, e_done;
  logic e_tmo, e_send;
  logic [W-1:0] e_data;
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_rel = 0; m_age = 0; m_seen = 0;
      e_grant = '0; e_done = '0; e_tmo = 0; e_send = 0; e_data = '0;
    end else begin
      e_done = '0; e_tmo = 0; e_send = 0;
      if (m_rel) begin
        m_rel = 0;
        e_grant = '0;
      end else if (m_owner < 0) begin
        if (req != 0 && !spi_busy) begin
          for (int k = 1; k <= N; k++)
            if (m_owner < 0 && req[(m_last + k) % N]) m_owner = (m_last + k) % N;
          m_last = m_owner;
          e_grant = N'(1 << m_owner);
          e_data = req_data[m_owner*W +: W];
          e_send = 1;
          m_age = 0;
          m_seen = 0;
        end
      end else begin
        m_age++;
        if (m_age >= 2) begin
          if (!m_seen) begin
            if (spi_busy) m_seen = 1;
            else if (m_age == T + 1) begin e_tmo = 1; m_rel = 1; m_owner = -1; end
          end else if (!spi_busy) begin
            e_done = N'(1 << m_owner); m_rel = 1; m_owner = -1;
          end
        end
      end
    end
  end

  int vec = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  bit chk_on = 0;
  int s_cyc[$], s_idx[$];
  logic [W-1:0] s_dat[$];
  int done_n[N];
  int tmo_cyc = 0, ev_n = 0;
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("grant", grant_o, e_grant);
      chk("done", done_o, e_done);
      chk("timeout_err", timeout_err_o, e_tmo);
      chk("spi_send", spi_send_o, e_send);
      chk("spi_data", spi_data_o, e_data);
    end
    if (spi_send_o) begin
      s_cyc.push_back(cyc);
      s_idx.push_back(oh2i(grant_o));
      s_dat.push_back(spi_data_o);
    end
    if (timeout_err_o) begin tmo_cyc = cyc; ev_n++; end
    if (done_o != 0) ev_n++;
    for (int i = 0; i < N; i++) if (done_o[i]) done_n[i]++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic set_word(input int i, input logic [W-1:0] w);
    req_data[i*W +: W] = w;
  endtask

  task automatic wait_send(input int maxc);
    int base = s_cyc.size();
    int k = 0;
    while (s_cyc.size() == base && k < maxc) begin tick(1); k++; end
    chk("send_seen", 32'(s_cyc.size() > base), 1);
  endtask

  task automatic wait_end(input int maxc);
    int base = ev_n;
    int k = 0;
    while (ev_n == base && k < maxc) begin tick(1); k++; end
    chk("end_seen", 32'(ev_n > base), 1);
  endtask

  int exp_ord[5] = '{0, 1, 2, 3, 0};
  logic [W-1:0] w2[4] = '{18'h0A000, 18'h0B001, 18'h0C002, 18'h0D003};
  int base, k;

  initial begin
    tick(1);
    chk_on = 1;
    tick(2);
    rst = 0;
    chk("rst_grant", grant_o, 0);
    chk("rst_send", spi_send_o, 0);
    chk("rst_data", spi_data_o, 0);
    // 1: single requester
    bl = 40;
    set_word(2, 18'h2ABCD);
    req = 4'b0100;
    wait_send(10);
    tick(20);
    chk("t1_grant_mid", grant_o, 4'b0100);
    wait_end(100);
    chk("t1_done", done_o, 4'b0100);
    req = '0;
    tick(3);
    chk("t1_sends", s_cyc.size(), 1);
    chk("t1_data", s_dat[0], 18'h2ABCD);
    chk("t1_done_n", done_n[2], 1);
    // 2: all four requesting from a fresh reset
    rst = 1; tick(1); rst = 0;
    bl = 5;
    for (int i = 0; i < N; i++) set_word(i, w2[i]);
    base = s_cyc.size();
    req = 4'b1111;
    k = 0;
    while (s_cyc.size() < base + 5 && k < 100) begin tick(1); k++; end
    req = '0;
    chk("t2_sends", 32'(s_cyc.size() >= base + 5), 1);
    wait_end(50);
    tick(3);
    for (int j = 0; j < 5; j++) if (s_cyc.size() > base + j) begin
      chk("t2_order", s_idx[base+j], exp_ord[j]);
      chk("t2_word", s_dat[base+j], w2[exp_ord[j]]);
      if (j > 0) chk("t2_gap", s_cyc[base+j] - s_cyc[base+j-1], 8);
    end
    // 3: master never starts, then next requester served
    bl = 0;
    base = s_cyc.size();
    req = 4'b0110;
    wait_send(5);
    wait_end(30);
    bl = 6;
    chk("t3_tmo", timeout_err_o, 1);
    chk("t3_done", done_o, 0);
    if (s_cyc.size() > base) begin
      chk("t3_owner", s_idx[base], 1);
      chk("t3_tmo_lat", tmo_cyc - s_cyc[base], 9);
    end
    tick(1);
    chk("t3_grant_clr", grant_o, 0);
    wait_send(5);
    chk("t3_next", grant_o, 4'b0100);
    wait_end(30);
    chk("t3_done2", done_o, 4'b0100);
    req = '0;
    tick(3);
    // 4: master still busy before the request
    force_busy = 1;
    req = 4'b0010;
    base = s_cyc.size();
    tick(10);
    chk("t4_nogrant", grant_o, 0);
    chk("t4_nosend", s_cyc.size(), base);
    force_busy = 0;
    tick(1);
    chk("t4_send", spi_send_o, 1);
    chk("t4_grant", grant_o, 4'b0010);
    wait_end(30);
    req = '0;
    tick(3);
    // 5: reset in the middle of a long transfer
    bl = 30;
    req = 4'b1000;
    wait_send(5);
    tick(5);
    rst = 1;
    #1;
    chk("t5_rst_grant", grant_o, 0);
    chk("t5_rst_send", spi_send_o, 0);
    chk("t5_rst_done", done_o, 0);
    tick(1);
    rst = 0;
    req = 4'b0011;
    base = s_cyc.size();
    k = 0;
    while (spi_busy && k < 60) begin tick(1); k++; end
    chk("t5_busy_fell", spi_busy, 0);
    chk("t5_nosend", s_cyc.size(), base);
    tick(1);
    chk("t5_send", spi_send_o, 1);
    chk("t5_grant", grant_o, 4'b0001);
    wait_end(60);
    req = '0;
    tick(3);
    // 6: request withdrawn and word changed mid-transfer
    bl = 10;
    set_word(3, 18'h31111);
    req = 4'b1000;
    wait_send(5);
    tick(3);
    req = '0;
    set_word(3, 18'h02222);
    wait_end(30);
    chk("t6_done", done_o, 4'b1000);
    chk("t6_data", spi_data_o, 18'h31111);
    tick(3);
    chk("t6_sent", s_dat[s_dat.size()-1], 18'h31111);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
